// File: rtl/rf_write_queue.sv
// rf_write_queue
//   Producer-side writeback buffer for the 8x16 bypassing register file.
//   Upstream write requests enter through a valid/ready handshake, wait in an
//   in-order FIFO and retire through the register file's single write port,
//   one entry per cycle unless rf_stall is high. Queued data is forwarded to
//   two read selectors so readers never observe stale register contents.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   DW     data width
//   AW     register-select width
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   in_valid/in_ready        request handshake (in_ready = count < DEPTH)
//   in_regsel/in_data        request destination register and data
//   rf_stall                 hold the head entry; no RF write this cycle
//   writeregsel/writedata    head entry to the RF (0 when empty)
//   write                    RF write enable (= !empty && !rf_stall)
//   read1regsel/read2regsel  forwarding lookup selects
//   fwd1_hit/fwd1_data       port-1 youngest queued match (data 0 if none)
//   fwd2_hit/fwd2_data       port-2 youngest queued match (data 0 if none)
//   count                    current occupancy
//   err                      sticky protocol error; present only when the
//                            RF_WQ_ERR_EN macro is defined
module rf_write_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_regsel,
  input  logic [DW-1:0]              in_data,
  input  logic                       rf_stall,
  output logic [AW-1:0]              writeregsel,
  output logic [DW-1:0]              writedata,
  output logic                       write,
  input  logic [AW-1:0]              read1regsel,
  input  logic [AW-1:0]              read2regsel,
  output logic                       fwd1_hit,
  output logic [DW-1:0]              fwd1_data,
  output logic                       fwd2_hit,
  output logic [DW-1:0]              fwd2_data,
  output logic [$clog2(DEPTH):0]     count
`ifdef RF_WQ_ERR_EN
  ,
  output logic                       err
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FullCount = (PW+1)'(DEPTH);

  logic [AW-1:0] regsel_q [DEPTH];
  logic [DW-1:0] data_q   [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   count_q;

  logic empty, push, pop;

  always_comb begin
    empty       = (count_q == '0);
    in_ready    = (count_q != FullCount);
    write       = !empty && !rf_stall;
    push        = in_valid && in_ready;
    pop         = write;
    writeregsel = empty ? '0 : regsel_q[head_q];
    writedata   = empty ? '0 : data_q[head_q];
    count       = count_q;
  end

  // Walk entries from oldest to youngest so the last match seen (youngest) wins.
  // The head entry stays valid until the edge that retires it, so it still hits.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((PW+1)'(k) < count_q) begin
        if (regsel_q[idx] == read1regsel) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_q[idx];
        end
        if (regsel_q[idx] == read2regsel) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_q[idx];
        end
      end
    end
  end

  // Pointers are PW bits wide, so DEPTH-1 -> 0 wrap is the natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regsel_q[i] <= '0;
        data_q[i]   <= '0;
      end
    end else begin
      if (push) begin
        regsel_q[tail_q] <= in_regsel;
        data_q[tail_q]   <= in_data;
        tail_q           <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef RF_WQ_ERR_EN
  // A request refused last cycle must be held unchanged until accepted.
  logic          stalled_q;
  logic [AW-1:0] prev_regsel_q;
  logic [DW-1:0] prev_data_q;
  logic          err_q;
  logic          viol;

  always_comb begin
    viol = 1'b0;
    if (stalled_q && (!in_valid || (in_regsel != prev_regsel_q) ||
                      (in_data != prev_data_q))) begin
      viol = 1'b1;
    end
    if (in_valid && ($isunknown(in_regsel) || $isunknown(in_data))) begin
      viol = 1'b1;
    end
    err = err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stalled_q     <= 1'b0;
      prev_regsel_q <= '0;
      prev_data_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      stalled_q     <= in_valid && !in_ready;
      prev_regsel_q <= in_regsel;
      prev_data_q   <= in_data;
      err_q         <= err_q | viol;
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_queue.sv
module tb_rf_write_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_regsel;
  logic [15:0] in_data;
  logic        rf_stall;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic        write;
  logic [2:0]  read1regsel;
  logic [2:0]  read2regsel;
  logic        fwd1_hit;
  logic [15:0] fwd1_data;
  logic        fwd2_hit;
  logic [15:0] fwd2_data;
  logic [2:0]  count;
`ifdef RF_WQ_ERR_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  rf_write_queue #(.DEPTH(DEPTH), .DW(16), .AW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_regsel   (in_regsel),
    .in_data     (in_data),
    .rf_stall    (rf_stall),
    .writeregsel (writeregsel),
    .writedata   (writedata),
    .write       (write),
    .read1regsel (read1regsel),
    .read2regsel (read2regsel),
    .fwd1_hit    (fwd1_hit),
    .fwd1_data   (fwd1_data),
    .fwd2_hit    (fwd2_hit),
    .fwd2_data   (fwd2_data),
    .count       (count)
`ifdef RF_WQ_ERR_EN
    ,
    .err         (err)
`endif
  );

  typedef struct packed {
    logic [2:0]  r;
    logic [15:0] d;
  } ent_t;

  ent_t model_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // Youngest queued entry for a register wins.
  task automatic lookup(input logic [2:0] sel, output logic hit, output logic [15:0] data);
    hit  = 1'b0;
    data = '0;
    foreach (model_q[i]) begin
      if (model_q[i].r == sel) begin
        hit  = 1'b1;
        data = model_q[i].d;
      end
    end
  endtask

  // One clock cycle: drive inputs, check all outputs mid-cycle, advance the model.
  task automatic step(input logic v, input logic [2:0] rs, input logic [15:0] d,
                      input logic st, input logic [2:0] r1, input logic [2:0] r2);
    logic        h1, h2, pushed, popped;
    logic [15:0] d1, d2;
    in_valid    = v;
    in_regsel   = rs;
    in_data     = d;
    rf_stall    = st;
    read1regsel = r1;
    read2regsel = r2;
    @(negedge clk);
    lookup(r1, h1, d1);
    lookup(r2, h2, d2);
    chk("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
    chk("write", 32'(write), 32'(model_q.size() > 0 && !st));
    chk("writeregsel", 32'(writeregsel), 32'(model_q.size() > 0 ? model_q[0].r : 3'd0));
    chk("writedata", 32'(writedata), 32'(model_q.size() > 0 ? model_q[0].d : 16'd0));
    chk("count", 32'(count), 32'(model_q.size()));
    chk("fwd1_hit", 32'(fwd1_hit), 32'(h1));
    chk("fwd1_data", 32'(fwd1_data), 32'(d1));
    chk("fwd2_hit", 32'(fwd2_hit), 32'(h2));
    chk("fwd2_data", 32'(fwd2_data), 32'(d2));
    pushed = v && (model_q.size() < DEPTH);
    popped = (model_q.size() > 0) && !st;
    @(posedge clk);
    if (popped) void'(model_q.pop_front());
    if (pushed) model_q.push_back('{r: rs, d: d});
    #1;
  endtask

  task automatic idle(input logic st);
    step(1'b0, 3'd0, 16'd0, st, 3'd0, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_regsel = '0; in_data = '0; rf_stall = 1'b0;
    read1regsel = '0; read2regsel = '0;
    #12;
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_writedata", 32'(writedata), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Idle after reset.
    repeat (3) idle(1'b0);

    // Single push retires the following cycle.
    step(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd3, 3'd0);
    chk("beef_write", 32'(write), 32'd1);
    chk("beef_sel", 32'(writeregsel), 32'd3);
    chk("beef_data", 32'(writedata), 32'hBEEF);
    idle(1'b0);
    chk("beef_drained", 32'(count), 32'd0);

    // Fill under stall, including a repeated register.
    step(1'b1, 3'd1, 16'h0001, 1'b1, 3'd1, 3'd2);
    step(1'b1, 3'd2, 16'h0002, 1'b1, 3'd1, 3'd2);
    step(1'b1, 3'd1, 16'h0011, 1'b1, 3'd1, 3'd2);
    step(1'b1, 3'd5, 16'h0005, 1'b1, 3'd1, 3'd5);
    read1regsel = 3'd1; read2regsel = 3'd7; #1;
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("fwd_young", 32'(fwd1_data), 32'h0011);
    chk("fwd_miss", 32'(fwd2_hit), 32'd0);

    // Drain from full; r6 offered while full is refused, then accepted.
    step(1'b1, 3'd6, 16'h0006, 1'b0, 3'd1, 3'd6);
    step(1'b1, 3'd6, 16'h0006, 1'b0, 3'd1, 3'd6);
    step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd1, 3'd6);
    step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd5, 3'd6);
    chk("r6_head", 32'(writedata), 32'h0006);
    idle(1'b0);
    chk("drained", 32'(count), 32'd0);

    // Simultaneous push and pop with two entries resident.
    step(1'b1, 3'd4, 16'hA000, 1'b1, 3'd4, 3'd0);
    step(1'b1, 3'd4, 16'hA001, 1'b1, 3'd4, 3'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'(i), 16'hB000 + 16'(i), 1'b0, 3'(i), 3'd4);
      chk("pp_count", 32'(count), 32'd2);
    end
    idle(1'b0);
    idle(1'b0);

    // Randomised traffic, light then heavy stalling.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom), 16'($urandom),
           (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 4) < 3),
           3'($urandom), 3'($urandom));
    end

    // Reset mid-drain at count 3.
    repeat (4) step(1'b1, 3'($urandom), 16'($urandom), 1'b1, 3'd0, 3'd0);
    while (model_q.size() > 3) idle(1'b0);
    while (model_q.size() < 3) step(1'b1, 3'd2, 16'h1234, 1'b1, 3'd0, 3'd0);
    in_valid = 1'b0; rf_stall = 1'b0; #1;
    chk("pre_rst_write", 32'(write), 32'd1);
    rst = 1'b0; #1;
    chk("async_write", 32'(write), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    model_q.delete();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    repeat (3) idle(1'b0);

`ifdef RF_WQ_ERR_EN
    // Protocol violation: refused request withdrawn before acceptance.
    chk("err_clear", 32'(err), 32'd0);
    repeat (4) step(1'b1, 3'd7, 16'h7777, 1'b1, 3'd7, 3'd0);
    step(1'b1, 3'd7, 16'h7777, 1'b1, 3'd7, 3'd0);
    chk("err_held", 32'(err), 32'd0);
    step(1'b0, 3'd7, 16'h7777, 1'b1, 3'd7, 3'd0);
    chk("err_set", 32'(err), 32'd1);
    repeat (6) idle(1'b0);
    chk("err_sticky", 32'(err), 32'd1);
    rst = 1'b0; #1;
    chk("err_reset", 32'(err), 32'd0);
    model_q.delete();
    #2 rst = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
